// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO (optional MULDIV_EARLY_TERM_EN)
module muldiv_hilo #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic                 isdiv_q, isdiv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sgn, s1, s2, mzero;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_r2, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        sgn   = (op == 3'd0) || (op == 3'd2);
        s1    = sgn & data1[WIDTH-1];
        s2    = sgn & data2[WIDTH-1];
        mag1  = s1 ? -data1 : data1;
        mag2  = s2 ? -data2 : data2;
        mzero = (data1 == '0) || (data2 == '0);

        // Accumulator holds {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Accumulator holds {partial remainder, dividend bits shifting into quotient}
        div_r2   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_r2 - {1'b0, a_q};
        div_next = div_diff[WIDTH] ? {div_r2[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod = neg_q  ? -acc_q : acc_q;
        quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        3'd0, 3'd1: begin
                            a_d     = mag1;
                            acc_d   = mzero ? '0 : {{WIDTH{1'b0}}, mag2};
                            neg_d   = s1 ^ s2;
                            rneg_d  = 1'b0;
                            dz_d    = 1'b0;
                            isdiv_d = 1'b0;
                            cnt_d   = '0;
                            state_d = S_MUL;
`ifdef MULDIV_EARLY_TERM_EN
                            if (mzero) state_d = S_FIX;
`endif
                        end
                        3'd2, 3'd3: begin
                            // A zero divisor parks {dividend, all-ones} so FIX yields hi=data1, lo='1
                            a_d     = mag2;
                            dz_d    = (data2 == '0);
                            acc_d   = (data2 == '0) ? {mag1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag1};
                            neg_d   = (s1 ^ s2) & (data2 != '0);
                            rneg_d  = s1;
                            isdiv_d = 1'b1;
                            cnt_d   = '0;
                            state_d = S_DIV;
`ifdef MULDIV_EARLY_TERM_EN
                            if (data2 == '0) state_d = S_FIX;
`endif
                        end
                        3'd4:    hi_d = data1;
                        3'd5:    lo_d = data1;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = dz_q ? acc_q : div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (isdiv_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            isdiv_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            isdiv_q <= isdiv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - directed self-checking bench for muldiv_hilo
module tb_muldiv_hilo;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_EARLY_TERM_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    muldiv_hilo #(.WIDTH(32), .ITER(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .data1  (data1),
        .data2  (data2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one mult/div, watches a fixed window and checks busy length, done timing and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ebusy, input bit spam);
        int busy_n = 0;
        int done_n = 0;
        int done_idx = 0;
        int chg = 0;
        int echg;
        logic [63:0] prev;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        data1 = a;
        data2 = b;
        prev  = {hi, lo};
        echg  = ({ehi, elo} !== prev) ? 1 : 0;
        @(posedge clk);
        #1;
        if (spam) begin
            op    = 3'd0;
            data1 = 32'd7;
            data2 = 32'd7;
        end else begin
            start = 1'b0;
            data1 = $urandom;
            data2 = $urandom;
        end
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_idx = i;
            end
            if ({hi, lo} !== prev) begin
                chg++;
                prev = {hi, lo};
            end
            if (!busy) start = 1'b0;
        end
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(ebusy));
        check({tag, " done_count"}, 64'(done_n), 64'd1);
        check({tag, " done_cycle"}, 64'(done_idx), 64'(ebusy + 1));
        check({tag, " hilo_changes"}, 64'(chg), 64'(echg));
        check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    initial begin
        int done_seen;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        data1  = 32'd0;
        data2  = 32'd0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;

        run_op("mult_neg2x3",  3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 33, 1'b0);
        run_op("multu_max",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
        run_op("div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
        run_op("divu_m7_2",    3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 33, 1'b0);
        run_op("divu_by0",     3'd3, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, ZLAT, 1'b0);
        run_op("div_by0",      3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, ZLAT, 1'b0);
        run_op("div_ovf",      3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
        run_op("div_7_m2",     3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0);
        run_op("divu_100_7",   3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0);
        run_op("mult_zero",    3'd0, 32'd5,        32'd0,        32'd0,        32'd0,        ZLAT, 1'b0);

        // MTHI then MTLO back to back
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        data1 = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        check("mthi hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
        check("mthi busy", {63'd0, busy}, 64'd0);
        op    = 3'd5;
        data1 = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo lo", {32'd0, lo}, {32'd0, 32'h5A5A5A5A});
        check("mtlo hi_kept", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
        check("mtlo busy", {63'd0, busy}, 64'd0);
        check("mtlo done", {63'd0, done}, 64'd0);

        // start held high while busy must not launch a second operation
        run_op("multu_spam", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 33, 1'b1);
        repeat (3) @(negedge clk);
        check("spam no_relaunch", {63'd0, busy}, 64'd0);

        // cancel mid divide
        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        data1 = 32'd100;
        data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel busy", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("cancel no_done", 64'(done_seen), 64'd0);
        check("cancel hi", {32'd0, hi}, 64'd0);
        check("cancel lo", {32'd0, lo}, 64'd6);

        // cancel in IDLE blocks a same-cycle start
        start  = 1'b1;
        cancel = 1'b1;
        op     = 3'd4;
        data1  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("idle_cancel hi", {32'd0, hi}, 64'd0);
        check("idle_cancel busy", {63'd0, busy}, 64'd0);

        // asynchronous reset mid divide
        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        data1 = 32'd100;
        data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset busy", {63'd0, busy}, 64'd0);
        check("areset hi", {32'd0, hi}, 64'd0);
        check("areset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("areset idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI and LO registers.
- Sits beside the single-cycle ALU in the execute stage and takes the same register-read operands (Data1 = rs, Data2 = rt).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives HI/LO to the writeback mux for MFHI/MFLO, and raises busy so the control path stalls dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration count of the shift-add / restoring-divide loop; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- data1  input  WIDTH  rs operand (multiplicand / dividend / MT source).
- data2  input  WIDTH  rt operand (multiplier / divisor).
- cancel  input  1  pipeline flush; aborts an in-flight operation.
- busy  output  1  unit occupied; HI/LO not yet valid.
- done  output  1  one-cycle pulse when HI/LO have just been updated by a mult/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulators cleared.
  - Applies immediately, including mid-operation.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 with op 4/5: write data1 to hi (op 4) or lo (op 5) at this edge; stay IDLE; done stays 0.
  - start=1 with op 0-3: latch operands. For signed ops, latch magnitudes plus result-sign flags. Clear the iteration counter. Go to MUL (op 0/1) or DIV (op 2/3).
  - start=1 with op 6/7: ignored.
- MUL:
  - One shift-add step per cycle into a 2*WIDTH accumulator.
  - After ITER steps, go to FIX.
- DIV:
  - One restoring-subtract step per cycle.
  - After ITER steps, go to FIX.
- FIX: one cycle.
  - Apply sign correction.
  - Write hi/lo at the exiting edge; go to IDLE; done=1 for the following cycle.
- Latency:
  - start accepted at edge E0; busy=1 for the 33 cycles after E0.
  - hi/lo change at edge E33.
  - done=1 and busy=0 in the cycle after E33.
  - A new start may be accepted at the edge that ends the done cycle.
- busy is a registered output: 1 in MUL, DIV and FIX; 0 in IDLE.
- start while busy=1 is ignored; no queueing; the control path must hold the instruction.
- Multiply results:
  - hi = product[63:32], lo = product[31:0].
  - MULT uses two's-complement signed operands; MULTU is unsigned.
- Divide results:
  - lo = quotient, hi = remainder; quotient truncated toward zero.
  - Signed: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Divide by zero: lo = 32'hFFFFFFFF, hi = data1, for both signed and unsigned.
- Signed overflow (0x80000000 / -1): lo = 32'h80000000, hi = 0.
- cancel:
  - cancel=1 in MUL/DIV/FIX: go to IDLE next edge; hi/lo unchanged; done not pulsed.
  - cancel has priority over FIX's write.
  - cancel in IDLE has no effect, and also blocks a same-cycle start.
- Operands are captured at acceptance; later changes on data1/data2 do not affect the result.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- Defined:
  - A divide with data2=0 goes IDLE->FIX directly.
  - A multiply with either operand zero goes IDLE->FIX directly.
  - In both cases busy is 1 for exactly 1 cycle and done pulses 2 cycles after the start edge.
  - Results are identical to the full-length case.
- Undefined: every mult/div takes the fixed 33-cycle busy window.

Test Plan:
- MULT data1=0xFFFFFFFE (-2), data2=3 -> after 33 busy cycles: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU data1=0xFFFFFFFF, data2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV data1=-7 (0xFFFFFFF9), data2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- DIVU data2=0, data1=0x1234 -> lo=0xFFFFFFFF, hi=0x1234. Busy is 33 cycles without MULDIV_EARLY_TERM_EN, 1 cycle with it.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A on consecutive cycles -> hi/lo update the next edge, busy stays 0, done stays 0. Then a start with op=0 asserted while busy=1 is ignored: hi/lo change only once.
- Start DIV 100/7, assert cancel at cycle 10 -> busy=0 next cycle, hi/lo keep their prior values, no done. Start DIV 100/7, drive rst_n low at cycle 20 -> hi=lo=0 and busy=0 immediately (asynchronous).
